// File: rtl/fixed_point_pkg.sv
// Shared constants, fixed-point type and FSM state encoding for the Q5.10 divider.
package fixed_point_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 10;

  typedef logic signed [WIDTH-1:0] fxp_t;

  localparam fxp_t FXP_MAX = 16'sh7FFF;
  localparam fxp_t FXP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ITER,
    DONE
  } div_state_t;
endpackage

// File: rtl/restoring_div_core.sv
// Unsigned radix-2 restoring divider core: one quotient bit per clock, MSB first.
module restoring_div_core #(
  parameter int DEN_W = 17,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DEN_W-1:0] rem_init,
  input  logic [ITERS-1:0] bits_in,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             last,
  output logic [ITERS-1:0] quo
);
  import fixed_point_pkg::*;

  localparam int CW = $clog2(ITERS + 1);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [ITERS-1:0] bits_q, bits_d;
  logic [ITERS-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DEN_W:0]   trial;

  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    bits_d = bits_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, bits_q[ITERS-1]};
    if (load) begin
      rem_d  = rem_init;
      den_d  = den;
      bits_d = bits_in;
      quo_d  = '0;
      cnt_d  = CW'(ITERS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder stays below den, so the restored trial always fits DEN_W bits.
      if (trial >= {1'b0, den_q}) begin
        rem_d = DEN_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[ITERS-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[ITERS-2:0], 1'b0};
      end
      bits_d = bits_q << 1;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      bits_q <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      bits_q <= bits_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign last = busy_q && (cnt_q == CW'(1));
  assign quo  = quo_q;
endmodule

// File: rtl/fixed_point_divider.sv
// Signed Q5.10 sequential divider: sign/saturation/handshake wrapper around restoring_div_core.
// Optional macro DIV_ROUND_NEAREST_EN: extra guard iteration, round half away from zero.
module fixed_point_divider #(
  parameter int WIDTH = fixed_point_pkg::WIDTH,
  parameter int FRAC  = fixed_point_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish
);
  import fixed_point_pkg::*;

  localparam int NW = WIDTH + FRAC + 1;
  localparam int DW = WIDTH + 1;
`ifdef DIV_ROUND_NEAREST_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam logic [DW-1:0] POS_LIM = DW'((1 << (WIDTH - 1)) - 1);
  localparam logic [DW-1:0] NEG_LIM = DW'(1 << (WIDTH - 1));

  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [DW-1:0] round_mag(input logic [QW-1:0] q);
`ifdef DIV_ROUND_NEAREST_EN
    return DW'(q[QW-1:1]) + DW'(q[0]);
`else
    return DW'(q);
`endif
  endfunction

  function automatic logic mag_overflow(input logic neg, input logic [DW-1:0] m);
    return neg ? (m > NEG_LIM) : (m > POS_LIM);
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                         input logic [WIDTH-1:0] m);
    logic signed [WIDTH-1:0] s;
    s = $signed(m);
    return neg ? -s : s;
  endfunction

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             finish_q, finish_d;
  logic             core_load, core_busy, core_last;
  logic [QW-1:0]    core_quo, core_bits;
  logic [DW-1:0]    a_ext, b_ext, mag_a, mag_b, q_mag;
  logic [NW-1:0]    num;
  logic [FRAC:0]    num_hi;

  // Magnitudes carry one extra bit so the most negative operand is exact.
  assign a_ext  = {a_q[WIDTH-1], a_q};
  assign b_ext  = {b_q[WIDTH-1], b_q};
  assign mag_a  = a_ext[WIDTH] ? -a_ext : a_ext;
  assign mag_b  = b_ext[WIDTH] ? -b_ext : b_ext;
  assign num    = {mag_a, {FRAC{1'b0}}};
  assign num_hi = num[NW-1:WIDTH];
`ifdef DIV_ROUND_NEAREST_EN
  assign core_bits = {num[WIDTH-1:0], 1'b0};
`else
  assign core_bits = num[WIDTH-1:0];
`endif
  assign q_mag = round_mag(core_quo);

  restoring_div_core #(
    .DEN_W(DW),
    .ITERS(QW)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (core_load),
    .rem_init(DW'(num_hi)),
    .bits_in (core_bits),
    .den     (mag_b),
    .busy    (core_busy),
    .last    (core_last),
    .quo     (core_quo)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    pend_d    = pend_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    finish_d  = finish_q;
    core_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          finish_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        sign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        // Upper numerator bits >= divisor means the quotient needs more than WIDTH bits.
        if ((b_q == '0) || (DW'(num_hi) >= mag_b)) begin
          pend_d  = 1'b1;
          state_d = DONE;
        end else begin
          pend_d    = 1'b0;
          core_load = 1'b1;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (core_last) state_d = DONE;
      end
      DONE: begin
        finish_d = 1'b1;
        state_d  = IDLE;
        if (pend_q || mag_overflow(sign_q, q_mag)) begin
          ovf_d    = 1'b1;
          result_d = sat_value(sign_q);
        end else begin
          ovf_d    = 1'b0;
          result_d = apply_sign(sign_q, q_mag[WIDTH-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      pend_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      finish_q <= finish_d;
    end
  end

  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign finish        = finish_q;

  logic unused_ok;
  assign unused_ok = core_busy;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: driver queues expectations, monitor checks on finish.
module tb_fixed_point_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] result;
  logic        overflow_flag;
  logic        finish;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        cmp_res;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic fin_prev = 1'b0;

  fixed_point_divider dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (A),
    .B            (B),
    .start        (start),
    .result       (result),
    .overflow_flag(overflow_flag),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic ovf, input logic cmp_res);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.cmp_res = cmp_res;
    return e;
  endfunction

  function automatic exp_t golden(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, ma, mb, q;
    bit     neg;
    exp_t   e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    neg = (sa < 0) ^ (sb < 0);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    e.cmp_res = 1'b1;
    if (mb == 0) begin
      e.ovf = 1'b1;
      e.res = neg ? 16'h8000 : 16'h7FFF;
      return e;
    end
`ifdef DIV_ROUND_NEAREST_EN
    q = (ma * 2048) / mb;
    q = (q >> 1) + (q & 1);
`else
    q = (ma * 1024) / mb;
`endif
    if ((!neg && q > 32767) || (neg && q > 32768)) begin
      e.ovf = 1'b1;
      e.res = neg ? 16'h8000 : 16'h7FFF;
    end else begin
      e.ovf = 1'b0;
      e.res = neg ? 16'(-q) : 16'(q);
    end
    return e;
  endfunction

  // Monitor: one expectation consumed per rising edge of finish.
  always @(negedge clk) begin
    if (finish && !fin_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_finish actual=result 0x%0h required=no completion", result);
      end else begin
        mon_e = sb_q.pop_front();
        check1("overflow_flag", 32'(overflow_flag), 32'(mon_e.ovf));
        if (mon_e.cmp_res) check1("result", 32'(result), 32'(mon_e.res));
      end
    end
    fin_prev <= finish;
  end

  task automatic wait_finish();
    int lat;
    lat = 1;
    while (!finish && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!finish || lat > 24) begin
      failures++;
      $display("FAIL latency actual=%0d required<=24", lat);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    sb_q.push_back(e);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [15:0] ra, rb;

    repeat (2) @(negedge clk);
    check1("reset_finish", 32'(finish), 32'd0);
    check1("reset_result", 32'(result), 32'd0);
    check1("reset_ovf", 32'(overflow_flag), 32'd0);
    rst_n = 1'b1;

    run_op(16'h0C00, 16'h0800, mk(16'h0600, 1'b0, 1'b1));
    run_op(16'hF400, 16'h0800, mk(16'hFA00, 1'b0, 1'b1));
    run_op(16'h0400, 16'h0C00, mk(16'h0155, 1'b0, 1'b1));
    run_op(16'hFC00, 16'h0C00, mk(16'hFEAB, 1'b0, 1'b1));
    run_op(16'h4000, 16'h0040, mk(16'h7FFF, 1'b1, 1'b0));
    run_op(16'h8000, 16'h0400, mk(16'h8000, 1'b0, 1'b1));
    run_op(16'h8000, 16'hFC00, mk(16'h7FFF, 1'b1, 1'b0));
    run_op(16'h7FFF, 16'h0400, mk(16'h7FFF, 1'b0, 1'b1));
    run_op(16'h0000, 16'h8000, mk(16'h0000, 1'b0, 1'b1));

    // A start while the divider is busy must be ignored.
    sb_q.push_back(mk(16'h0600, 1'b0, 1'b1));
    @(negedge clk);
    A = 16'h0C00;
    B = 16'h0800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 16'h0400;
    B = 16'h0C00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish();

    run_op(16'h1234, 16'h0000, mk(16'h7FFF, 1'b1, 1'b1));

    // Abort an operation mid-iteration with an asynchronous reset pulse.
    @(negedge clk);
    A = 16'h0C00;
    B = 16'h0800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("abort_finish", 32'(finish), 32'd0);
    check1("abort_result", 32'(result), 32'd0);
    check1("abort_ovf", 32'(overflow_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'hF400, 16'h0800, mk(16'hFA00, 1'b0, 1'b1));

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      if (i % 3 == 0) rb = 16'($urandom_range(0, 255));
      else rb = 16'($urandom);
      if (i % 17 == 0) rb = 16'h0000;
      e = golden(ra, rb);
      if (e.ovf) e.cmp_res = 1'b0;
      run_op(ra, rb, e);
    end

    repeat (5) @(negedge clk);
    check1("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider for the ODE accelerator datapath.
- Computes result = A / B on 16-bit two's-complement Q5.10 operands (1 sign, 5 integer, 10 fraction bits).
- Radix-2 restoring division on magnitudes, one quotient bit per clock.
- Signals completion with a level `finish` flag and reports overflow or divide-by-zero on `overflow_flag`.

Parameters:
- WIDTH, 16, total operand/result width in bits.
- FRAC, 10, number of fractional bits. FRAC must be less than WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  dividend, signed Q5.10.
- B  input  WIDTH  divisor, signed Q5.10.
- start  input  1  one-cycle (or longer) request; sampled on the rising edge.
- result  output  WIDTH  quotient, signed Q5.10.
- overflow_flag  output  1  quotient not representable, or B == 0.
- finish  output  1  result and overflow_flag valid; held until the next start.

Behaviour:
- Reset (rst_n = 0, asynchronous): state IDLE; result = 0; overflow_flag = 0; finish = 0; all internal registers cleared.
- States: IDLE, SETUP, ITER, DONE.
- IDLE:
  - On the first edge with start = 1, latch A and B, clear finish and overflow_flag, go to SETUP.
- SETUP:
  - sign = A[MSB] XOR B[MSB].
  - magA = |A| and magB = |B|, each WIDTH+1 bits so that -32768 is handled.
  - Numerator N = magA << FRAC (WIDTH+FRAC+1 bits).
  - If B == 0: overflow_flag = 1, result = saturated value, go to DONE.
  - Otherwise load remainder and counter (WIDTH iterations), go to ITER.
  - Saturated value is 0x7FFF when sign = 0 and 0x8000 when sign = 1.
- ITER, one quotient bit per cycle, MSB first:
  - Shift the remainder/numerator left by one.
  - If remainder >= magB: subtract magB and set the quotient bit to 1.
  - Before the first iteration, if (N >> WIDTH) >= magB the magnitude quotient is at least 2^WIDTH: flag overflow and jump to DONE.
- DONE (entered after the last iteration):
  - Apply the sign to the magnitude quotient Q.
  - If sign = 0 and Q > 2^(WIDTH-1) - 1: overflow.
  - If sign = 1 and Q > 2^(WIDTH-1): overflow.
  - On overflow, result = saturated value and overflow_flag = 1.
  - Set finish = 1 and return to IDLE. Outputs hold until the next start.
- Rounding: truncation toward zero.
- Latency: finish rises at most 18 clocks after the edge that samples start; it must never exceed 24 clocks.
- A start while busy is ignored. A start in IDLE with finish = 1 begins a new operation and drops finish on that edge.
- Reset mid-operation aborts immediately; outputs return to their reset values.
- result is unspecified-but-stable when overflow_flag = 1. The saturated value above is the implemented choice.

Optional Feature:
- Macro: DIV_ROUND_NEAREST_EN.
- Defined:
  - One extra iteration produces a guard bit.
  - The magnitude quotient is incremented when the guard bit = 1 (round half away from zero).
  - The overflow check is applied after rounding.
  - Latency +1 cycle.
- Undefined: pure truncation toward zero, as above.

Decomposition:
- Package fixed_point_pkg holds:
  - WIDTH and FRAC constants.
  - Typedef fxp_t (logic signed [WIDTH-1:0]).
  - Saturation constants FXP_MAX = 0x7FFF and FXP_MIN = 0x8000.
  - State enum div_state_t.
- One natural sub-module, restoring_div_core: unsigned iterative magnitude divider. The wrapper handles sign, saturation and handshake.

Test Plan:
- A=0x0C00 (3.0), B=0x0800 (2.0), start 1 cycle -> within 24 clocks finish=1, result=0x0600 (1.5), overflow_flag=0.
- A=0xF400 (-3.0), B=0x0800 -> result=0xFA00 (-1.5), overflow_flag=0.
- A=0x0400 (1.0), B=0x0C00 (3.0) -> result=0x0155 (truncated), overflow_flag=0; A=0xFC00, B=0x0C00 -> result=0xFEAB.
- A=0x1234, B=0x0000 -> finish=1, overflow_flag=1, result=0x7FFF; A=0x4000 (16.0), B=0x0040 (0.0625) -> overflow_flag=1.
- 100 back-to-back ops (start high 1 cycle, check 24 cycles later) against a golden model; overflow ops compare only the flag.
- Pulse rst_n low mid-ITER -> finish=0, result=0, overflow_flag=0 immediately; next start completes correctly.
